mult_result_fifo: RTL and testbench

MULT_RESULT_FIFO -- requirements
Module: mult_result_fifo

---
 rtl/mult_result_fifo.sv | 97 +++++++++
 tb/tb_mult_result_fifo.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: queues {product, operand A, operand B} from a 10-phase shared multiplier
// Optional feature: define MULT_RESULT_CHECK_EN to recompute op_a*op_b at push time and flag mismatches.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   in1, in2          - operands tapped from the multiplier input, latched at phase 0
//   prod              - multiplier output, captured at phase 9
//   res_ready         - consumer ready; head is popped when res_valid && res_ready
//   res_valid         - registered head-valid (occupancy > 0)
//   res_data/a/b      - registered head product and operands
//   overflow          - sticky, set when a push is dropped on a full FIFO
//   drop_cnt          - saturating count of dropped pushes
//   chk_err           - sticky product self-check mismatch (0 unless MULT_RESULT_CHECK_EN)
module mult_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [15:0] prod,
    input  logic        res_ready,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [7:0]  res_a,
    output logic [7:0]  res_b,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        chk_err
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    phase;
    logic [7:0]    op_a, op_b;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0]   count, cnt_next, remain;
    logic          push, pop, full, push_ok, drop;
    logic [31:0]   entry, head_next;

    assign push     = phase == 4'd9;
    assign pop      = res_valid && res_ready;
    assign full     = count == (AW+1)'(DEPTH);
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign entry    = {prod, op_a, op_b};
    assign remain   = count - (AW+1)'(pop);
    assign cnt_next = remain + (AW+1)'(push_ok);
    assign rd_next  = rd_ptr + AW'(pop);
    // When the FIFO drains to nothing this edge, the only possible new head is
    // the entry being written; otherwise the head is an existing, untouched slot.
    assign head_next = (remain == 0) ? (push_ok ? entry : 32'd0) : mem[rd_next];

    always_ff @(posedge clk)
        if (push_ok && !rst) mem[wr_ptr] <= entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 4'd0;
            op_a      <= 8'd0;
            op_b      <= 8'd0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= 16'd0;
            res_a     <= 8'd0;
            res_b     <= 8'd0;
            overflow  <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            phase     <= push ? 4'd0 : phase + 4'd1;
            if (phase == 4'd0) begin
                op_a <= in1;
                op_b <= in2;
            end
            rd_ptr    <= rd_next;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            count     <= cnt_next;
            res_valid <= cnt_next != 0;
            res_data  <= head_next[31:16];
            res_a     <= head_next[15:8];
            res_b     <= head_next[7:0];
            if (drop) overflow <= 1'b1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef MULT_RESULT_CHECK_EN
    // Checked on every phase-9 push, including ones that end up dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_err <= 1'b0;
        else if (push && (16'(op_a) * 16'(op_b)) != prod) chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_mult_result_fifo.sv
// tb_mult_result_fifo: directed self-checking bench for mult_result_fifo
module tb_mult_result_fifo;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  in1 = 8'd0, in2 = 8'd0;
    logic [15:0] prod = 16'd0;
    logic        res_ready = 1'b0;
    logic        res_valid, overflow, chk_err;
    logic [15:0] res_data;
    logic [7:0]  res_a, res_b, drop_cnt;
    logic        exp_chk;
    int          passed = 0, total = 0;
    logic [15:0] drain_exp [4];

    mult_result_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .prod(prod),
        .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
        .res_a(res_a), .res_b(res_b), .overflow(overflow),
        .drop_cnt(drop_cnt), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                       input logic r_first, input logic r_rest);
        in1 = a;
        in2 = b;
        prod = p;
        res_ready = r_first;
        cyc(1);
        res_ready = r_rest;
        cyc(9);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_data"}, res_data, 0);
        chk({tag, "_a"}, res_a, 0);
        chk({tag, "_b"}, res_b, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_chk"}, chk_err, 0);
    endtask

    initial begin
`ifdef MULT_RESULT_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        cyc(2);
        chk_zero("reset");
        rst = 1'b0;
        run(8'd13, 8'd11, 16'd143, 1'b1, 1'b1);
        chk("r1_valid", res_valid, 1);
        chk("r1_data", res_data, 143);
        chk("r1_a", res_a, 13);
        chk("r1_b", res_b, 11);
        in1 = 8'd255; in2 = 8'd255; prod = 16'd65025;
        cyc(1);
        chk("r1_popped", res_valid, 0);
        cyc(9);
        chk("r2_data", res_data, 65025);
        chk("r2_a", res_a, 255);
        run(8'd0, 8'd200, 16'd0, 1'b1, 1'b1);
        chk("r3_valid", res_valid, 1);
        chk("r3_data", res_data, 0);
        chk("r3_b", res_b, 200);
        run(8'd1, 8'd2, 16'd2, 1'b1, 1'b0);
        run(8'd3, 8'd4, 16'd12, 1'b0, 1'b0);
        run(8'd5, 8'd6, 16'd30, 1'b0, 1'b0);
        run(8'd7, 8'd8, 16'd56, 1'b0, 1'b0);
        chk("full_ovf", overflow, 0);
        run(8'd9, 8'd10, 16'd90, 1'b0, 1'b0);
        chk("drop_ovf", overflow, 1);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_head", res_data, 2);
        chk("drop_head_a", res_a, 1);
        in1 = 8'd11; in2 = 8'd12; prod = 16'd132; res_ready = 1'b0;
        cyc(9);
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
        chk("pp_head", res_data, 12);
        chk("pp_drop", drop_cnt, 1);
        drain_exp = '{16'd12, 16'd30, 16'd56, 16'd132};
        in1 = 8'd0; in2 = 8'd0; prod = 16'd0; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), res_data, 32'(drain_exp[i]));
            cyc(1);
        end
        chk("drain_empty", res_valid, 0);
        cyc(6);
        for (int i = 0; i < 300; i++) run(8'(i), 8'd3, 16'(8'(i) * 3), 1'b0, 1'b0);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_ovf", overflow, 1);
        rst = 1'b1;
        #1;
        chk_zero("rst1");
        cyc(1);
        rst = 1'b0;
        run(8'd4, 8'd5, 16'd20, 1'b0, 1'b0);
        run(8'd6, 8'd6, 16'd36, 1'b0, 1'b0);
        chk("two_head", res_data, 20);
        in1 = 8'd7; in2 = 8'd7; prod = 16'd49;
        cyc(5);
        #2 rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        run(8'd6, 8'd7, 16'd42, 1'b0, 1'b0);
        chk("after_valid", res_valid, 1);
        chk("after_data", res_data, 42);
        chk("after_a", res_a, 6);
        chk("after_b", res_b, 7);
        run(8'd2, 8'd3, 16'hFFFF, 1'b0, 1'b0);
        chk("chk_err", chk_err, 32'(exp_chk));
        run(8'd1, 8'd1, 16'd1, 1'b0, 1'b0);
        chk("chk_sticky", chk_err, 32'(exp_chk));
        chk("after_head", res_data, 42);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
